// File: rtl/interface_ov7670_uc_pkg.sv
// Shared definitions for the OV7670 capture control unit.
// Holds the state codes, the default sizing, and small helper functions.
package interface_ov7670_uc_pkg;

  // These codes are exported on db_estado, so their values are fixed.
  typedef enum logic [3:0] {
    REPOUSO      = 4'd0,
    ZERA         = 4'd1,
    DISPARA      = 4'd2,
    ESPERA_TX    = 4'd3,
    ESPERA_ALTO  = 4'd4,
    ESPERA_BAIXO = 4'd5,
    AVALIA       = 4'd6,
    ARMAZENA     = 4'd7,
    AVANCA       = 4'd8,
    FIM          = 4'd9,
    ERRO         = 4'd10
  } estado_t;

  localparam int unsigned LINES_DEFAULT     = 120;
  localparam int unsigned COLUMNS_DEFAULT   = 320;
  localparam int unsigned N_SAMPLES_DEFAULT = 9;
  localparam int unsigned TIMEOUT_DEFAULT   = 2500000;  // 50 ms at 50 MHz

  // Returns the counter width for values 0..n-1, with a minimum of one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The three states that wait on the UART or the camera are guarded by the watchdog.
  function automatic logic is_espera(input estado_t s);
    return (s == ESPERA_TX) || (s == ESPERA_ALTO) || (s == ESPERA_BAIXO);
  endfunction

endpackage

// File: rtl/interface_ov7670_uc_if.sv
// Bundle of the status flags and control strobes shared by the control unit and the capture datapath.
// master = control unit (drives the strobes); slave = datapath and camera side.
interface interface_ov7670_uc_if;
  logic       iniciar;
  logic       fim_transmissao;
  logic       fim_recepcao;
  logic       escreve_byte;
  logic       fim_coluna_pixel;

  logic       zera_linha_pixel;
  logic       zera_coluna_pixel;
  logic       conta_coluna_pixel;
  logic       zera_linha_quadrante;
  logic       zera_coluna_quadrante;
  logic       conta_linha_quadrante;
  logic       conta_coluna_quadrante;
  logic       we_byte;
  logic       partida_serial;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, fim_transmissao, fim_recepcao, escreve_byte, fim_coluna_pixel,
    output zera_linha_pixel, zera_coluna_pixel, conta_coluna_pixel,
           zera_linha_quadrante, zera_coluna_quadrante,
           conta_linha_quadrante, conta_coluna_quadrante,
           we_byte, partida_serial, pronto, erro, db_estado
  );

  modport slave (
    output iniciar, fim_transmissao, fim_recepcao, escreve_byte, fim_coluna_pixel,
    input  zera_linha_pixel, zera_coluna_pixel, conta_coluna_pixel,
           zera_linha_quadrante, zera_coluna_quadrante,
           conta_linha_quadrante, conta_coluna_quadrante,
           we_byte, partida_serial, pronto, erro, db_estado
  );
endinterface

// File: rtl/interface_ov7670_uc_watchdog_timer.sv
// Wait-state watchdog. It clears on request, counts while enabled, and flags
// expirou on the last allowed cycle so the owner can leave on the following edge.
module watchdog_timer
  import interface_ov7670_uc_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expirou
);

  localparam int unsigned         CNT_W = width_of(TIMEOUT);
  localparam logic [CNT_W-1:0]    LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Cycle counter: it holds at LAST instead of wrapping, so a late event can never re-arm it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expirou = enable && (cnt == LAST);

endmodule

// File: rtl/interface_ov7670_uc.sv
// OV7670 capture control unit. It starts a capture, triggers the camera over
// serial, pairs the incoming bytes into pixels, and sequences the pixel and
// quadrant counters and the 3x3 sample RAM writes. All outputs are decoded from the state.
module interface_ov7670_uc
  import interface_ov7670_uc_pkg::*;
#(
  parameter int unsigned LINES     = LINES_DEFAULT,
  parameter int unsigned COLUMNS   = COLUMNS_DEFAULT,
  parameter int unsigned N_SAMPLES = N_SAMPLES_DEFAULT,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  interface_ov7670_uc_if.master bus
);

  localparam int unsigned      N_PIXELS   = LINES * COLUMNS;
  localparam int unsigned      PIX_W      = width_of(N_PIXELS);
  localparam int unsigned      SMP_W      = width_of(N_SAMPLES + 1);
  localparam logic [PIX_W-1:0] LAST_PIXEL = PIX_W'(N_PIXELS - 1);
  localparam logic [SMP_W-1:0] SMP_MAX    = SMP_W'(N_SAMPLES);

  estado_t          state, state_next;
  logic [PIX_W-1:0] pix_cnt;
  logic [SMP_W-1:0] smp_cnt;
  logic [1:0]       smp_mod3;   // sample index mod 3: position of the write inside its grid row
  logic             wd_clear, wd_enable, wd_expirou;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: registered state is updated with non-blocking assignments so that
    // every flop samples its inputs from the same pre-edge values.
    if (!reset) state <= REPOUSO;
    else        state <= state_next;
  end

  // Pixel and sample counters: cleared in ZERA, advanced in AVANCA and ARMAZENA.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_cnt  <= '0;
      smp_cnt  <= '0;
      smp_mod3 <= '0;
    end else begin
      case (state)
        ZERA: begin
          pix_cnt  <= '0;
          smp_cnt  <= '0;
          smp_mod3 <= '0;
        end
        ARMAZENA: begin
          smp_cnt  <= smp_cnt + 1'b1;
          smp_mod3 <= (smp_mod3 == 2'd2) ? 2'd0 : smp_mod3 + 2'd1;
        end
        AVANCA:  pix_cnt <= pix_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // The watchdog restarts on every entry into a wait state, including ALTO -> BAIXO.
  assign wd_enable = is_espera(state);
  assign wd_clear  = is_espera(state_next) && (state_next != state);

  watchdog_timer #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expirou (wd_expirou)
  );

  // Next-state logic and Moore decode of every datapath strobe.
  always_comb begin
    // NOTE: every output and the next state get a default before the case, so
    // no path leaves a value unassigned and no latch is inferred.
    state_next                 = state;
    bus.zera_linha_pixel       = 1'b0;
    bus.zera_coluna_pixel      = 1'b0;
    bus.conta_coluna_pixel     = 1'b0;
    bus.zera_linha_quadrante   = 1'b0;
    bus.zera_coluna_quadrante  = 1'b0;
    bus.conta_linha_quadrante  = 1'b0;
    bus.conta_coluna_quadrante = 1'b0;
    bus.we_byte                = 1'b0;
    bus.partida_serial         = 1'b0;
    bus.pronto                 = 1'b0;
    bus.erro                   = 1'b0;

    case (state)
      REPOUSO: if (bus.iniciar) state_next = ZERA;
      ZERA: begin
        bus.zera_linha_pixel      = 1'b1;
        bus.zera_coluna_pixel     = 1'b1;
        bus.zera_linha_quadrante  = 1'b1;
        bus.zera_coluna_quadrante = 1'b1;
        state_next                = DISPARA;
      end
      DISPARA: begin
        bus.partida_serial = 1'b1;
        state_next         = ESPERA_TX;
      end
      // In the wait states a real event takes priority over the watchdog on a tie.
      ESPERA_TX: begin
        if (bus.fim_transmissao) state_next = ESPERA_ALTO;
        else if (wd_expirou)     state_next = ERRO;
      end
      ESPERA_ALTO: begin
        if (bus.fim_recepcao) state_next = ESPERA_BAIXO;
        else if (wd_expirou)  state_next = ERRO;
      end
      ESPERA_BAIXO: begin
        if (bus.fim_recepcao) state_next = AVALIA;
        else if (wd_expirou)  state_next = ERRO;
      end
      AVALIA: begin
        if (bus.escreve_byte && (smp_cnt < SMP_MAX)) state_next = ARMAZENA;
        else                                          state_next = AVANCA;
      end
      // The RAM writes at the current quadrant address, which advances on the same edge.
      ARMAZENA: begin
        bus.we_byte                = 1'b1;
        bus.conta_coluna_quadrante = 1'b1;
        bus.conta_linha_quadrante  = (smp_mod3 == 2'd2);
        state_next                 = AVANCA;
      end
      AVANCA: begin
        bus.conta_coluna_pixel = 1'b1;
        state_next             = (pix_cnt == LAST_PIXEL) ? FIM : ESPERA_ALTO;
      end
      FIM: begin
        bus.pronto = 1'b1;
        if (bus.iniciar) state_next = ZERA;
      end
      ERRO: begin
        bus.erro = 1'b1;
        if (bus.iniciar) state_next = ZERA;
      end
      default: state_next = REPOUSO;
    endcase
  end

  assign bus.db_estado = state;

endmodule

// File: tb/tb_interface_ov7670_uc.sv
// Bench for the OV7670 capture control unit. Stimulus pushes the expected
// strobe events of each capture into a queue, computed from the frame rules.
// A forked monitor pops and compares whenever the DUT shows a strobe.
module tb_interface_ov7670_uc;
  import interface_ov7670_uc_pkg::*;

  localparam int LINES     = 2;
  localparam int COLUMNS   = 8;
  localparam int NPIX      = LINES * COLUMNS;
  localparam int N_SAMPLES = 9;
  localparam int TIMEOUT   = 20;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  interface_ov7670_uc_if bus ();

  interface_ov7670_uc #(
    .LINES(LINES), .COLUMNS(COLUMNS), .N_SAMPLES(N_SAMPLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {EV_NONE, EV_ZERA, EV_DISPARA, EV_WRITE, EV_AVANCA,
                    EV_PRONTO, EV_ERRO, EV_STRAY} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [4:0] info;
  } ev_t;

  ev_t exp_q[$];
  int  total   = 0;
  int  bad     = 0;
  int  we_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic ev_t mk(input ev_kind_t k, input logic [4:0] i);
    ev_t e;
    e.kind = k;
    e.info = i;
    return e;
  endfunction

  function automatic logic [14:0] outs();
    return {bus.zera_linha_pixel, bus.zera_coluna_pixel, bus.conta_coluna_pixel,
            bus.zera_linha_quadrante, bus.zera_coluna_quadrante,
            bus.conta_linha_quadrante, bus.conta_coluna_quadrante,
            bus.we_byte, bus.partida_serial, bus.pronto, bus.erro, bus.db_estado};
  endfunction

  // Scoreboard monitor: classifies each cycle's strobes and checks them against the queue.
  task automatic monitor();
    logic pronto_q = 1'b0;
    logic erro_q   = 1'b0;
    ev_t  obs, want;
    forever begin
      @(negedge clock);
      obs = mk(EV_NONE, 5'd0);
      if (bus.zera_linha_pixel | bus.zera_coluna_pixel | bus.zera_linha_quadrante |
          bus.zera_coluna_quadrante)
        obs = mk(EV_ZERA, {bus.zera_linha_pixel, bus.zera_coluna_pixel,
                           bus.zera_linha_quadrante, bus.zera_coluna_quadrante, 1'b1});
      else if (bus.partida_serial)
        obs = mk(EV_DISPARA, 5'd0);
      else if (bus.we_byte)
        obs = mk(EV_WRITE, {3'b000, bus.conta_coluna_quadrante, bus.conta_linha_quadrante});
      else if (bus.conta_linha_quadrante | bus.conta_coluna_quadrante)
        obs = mk(EV_STRAY, 5'd0);
      else if (bus.conta_coluna_pixel)
        obs = mk(EV_AVANCA, 5'd0);
      else if (bus.pronto && !pronto_q)
        obs = mk(EV_PRONTO, 5'd0);
      else if (bus.erro && !erro_q)
        obs = mk(EV_ERRO, 5'd0);
      pronto_q = bus.pronto;
      erro_q   = bus.erro;
      if (bus.we_byte) we_seen++;
      if (obs.kind != EV_NONE) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", obs.kind, EV_NONE);
        end else begin
          want = exp_q.pop_front();
          check("sb_kind", obs.kind, want.kind);
          check("sb_info", obs.info, want.info);
        end
      end
    end
  endtask

  // Waits (bounded) until every expected event has been observed.
  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check("drain", exp_q.size(), 0);
  endtask

  // Called at a negedge: one received byte after 'gap' idle cycles.
  task automatic send_byte(input int gap, input bit set_esc, input logic esc, input logic fim_col);
    repeat (gap) @(negedge clock);
    if (set_esc) begin
      bus.escreve_byte     = esc;
      bus.fim_coluna_pixel = fim_col;
    end
    bus.fim_recepcao = 1'b1;
    @(negedge clock);
    bus.fim_recepcao = 1'b0;
  endtask

  // Called at a negedge: iniciar pulse, then the UART acknowledge after a short delay.
  task automatic start_capture();
    bus.iniciar = 1'b1;
    @(negedge clock);
    bus.iniciar = 1'b0;
    check("zera_state", bus.db_estado, 4'd1);
    repeat ($urandom_range(2, 10)) @(negedge clock);
    bus.fim_transmissao = 1'b1;
    @(negedge clock);
    bus.fim_transmissao = 1'b0;
  endtask

  // Full frame. The expected event list follows from the sampling rules: pixel p
  // is stored when flagged and fewer than N_SAMPLES are stored so far, and every
  // third stored sample also advances the quadrant line.
  task automatic run_frame(input logic [NPIX-1:0] esc, input int tie_pix, input bit hold_ini);
    int written = 0;
    int we_base;
    int g;
    exp_q.push_back(mk(EV_ZERA, 5'h1f));
    exp_q.push_back(mk(EV_DISPARA, 5'd0));
    for (int p = 0; p < NPIX; p++) begin
      if (esc[p] && written < N_SAMPLES) begin
        exp_q.push_back(mk(EV_WRITE, {3'b000, 1'b1, (written % 3 == 2)}));
        written++;
      end
      exp_q.push_back(mk(EV_AVANCA, 5'd0));
    end
    exp_q.push_back(mk(EV_PRONTO, 5'd0));
    we_base = we_seen;
    start_capture();
    if (hold_ini) bus.iniciar = 1'b1;
    for (int p = 0; p < NPIX; p++) begin
      send_byte($urandom_range(3, 12), 1'b1, esc[p], (p % COLUMNS) == COLUMNS - 1);
      if (p == NPIX - 1) bus.iniciar = 1'b0;
      g = (p == tie_pix) ? TIMEOUT - 1 : $urandom_range(1, 12);
      send_byte(g, 1'b0, 1'b0, 1'b0);
    end
    wait_drain();
    check("frame_pronto", bus.pronto, 1'b1);
    check("frame_erro", bus.erro, 1'b0);
    check("frame_state", bus.db_estado, 4'd9);
    check("frame_writes", we_seen - we_base, written);
  endtask

  initial begin
    int n;
    logic [NPIX-1:0] pat;
    bus.iniciar          = 1'b0;
    bus.fim_transmissao  = 1'b0;
    bus.fim_recepcao     = 1'b0;
    bus.escreve_byte     = 1'b0;
    bus.fim_coluna_pixel = 1'b0;
    fork monitor(); join_none

    // Reset state.
    repeat (3) @(negedge clock);
    check("reset_outputs", outs(), 15'd0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_state", bus.db_estado, 4'd0);

    // Normal frame: samples at pixels 1, 2, 5.
    pat = '0;
    pat[1] = 1'b1;
    pat[2] = 1'b1;
    pat[5] = 1'b1;
    run_frame(pat, -1, 1'b0);

    // Random pattern, iniciar held high through the frame (must be ignored).
    pat = NPIX'($urandom);
    run_frame(pat, -1, 1'b1);

    // Saturation: every pixel flagged.
    run_frame('1, -1, 1'b0);

    // Timeout after the high byte.
    exp_q.push_back(mk(EV_ZERA, 5'h1f));
    exp_q.push_back(mk(EV_DISPARA, 5'd0));
    exp_q.push_back(mk(EV_ERRO, 5'd0));
    start_capture();
    send_byte(3, 1'b1, 1'b0, 1'b0);
    check("baixo_state", bus.db_estado, 4'd5);
    n = 0;
    while (bus.erro !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("timeout_cycles", n, TIMEOUT);
    check("erro_state", bus.db_estado, 4'd10);
    wait_drain();

    // Restart from ERRO; the low byte of pixel 3 lands on the expiry cycle.
    pat = NPIX'($urandom);
    run_frame(pat, 3, 1'b0);

    // Asynchronous reset while waiting for the high byte.
    exp_q.push_back(mk(EV_ZERA, 5'h1f));
    exp_q.push_back(mk(EV_DISPARA, 5'd0));
    start_capture();
    check("alto_state", bus.db_estado, 4'd4);
    #2 reset = 1'b0;
    #1 check("async_reset_outputs", outs(), 15'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("post_reset_state", bus.db_estado, 4'd0);
    check("post_reset_queue", exp_q.size(), 0);

    // A few random frames.
    for (int f = 0; f < 3; f++) begin
      pat = NPIX'($urandom);
      run_frame(pat, -1, 1'(f % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
